// File: rtl/fmc_pkg.sv
// -----------------------------------------------------------------------------
// fmc_pkg
// Shared types and constants for the FMC multiplexed-bus register bank.
//   fmc_state_e      : bus-cycle FSM state encoding
//   ADDR_ID          : address of the read-only ID register
//   ID_VALUE_DEFAULT : default content of the ID register
//   ERR_W            : width of the saturating bus-error counter
//   err_sat_inc()    : saturating increment for the error counter
// -----------------------------------------------------------------------------
package fmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } fmc_state_e;

    localparam logic [7:0]  ADDR_ID          = 8'hFF;
    localparam logic [15:0] ID_VALUE_DEFAULT = 16'hF3C1;
    localparam int          ERR_W            = 8;

    // Counter sticks at all-ones so a flood of errors never reads back as "few".
    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] cnt);
        logic [ERR_W-1:0] nxt;
        if (cnt == {ERR_W{1'b1}}) begin
            nxt = cnt;
        end else begin
            nxt = cnt + {{(ERR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fmc_sync.sv
// -----------------------------------------------------------------------------
// fmc_sync
// Parametrised-width two-flop synchroniser with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into both stages
//   d     : asynchronous input vector
//   q     : synchronised output vector (two clk of latency)
// -----------------------------------------------------------------------------
module fmc_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous bus pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/fmc_mux_regbank.sv
// -----------------------------------------------------------------------------
// fmc_mux_regbank
// STM32 FMC multiplexed address/data slave: N_RD read channels, N_WR write
// registers with one-cycle strobes, an ID register and a saturating bus-error
// counter. The bus is exposed as separate in / out / output-enable signals.
// Optional build macro FMC_SNAPSHOT_EN: reading channel 0 freezes all read
// channels into shadow registers so multi-channel reads are coherent.
// Ports:
//   sys_clk, sys_rst_n      : clock, asynchronous active-low reset
//   fmc_nadv/ne/nwe/noe     : FMC control strobes (active low, asynchronous)
//   fmc_db_i/o, fmc_db_oe   : bus input, registered drive value and enable
//   rd_data                 : flat read channels, channel k at [k*DATA_W +: DATA_W]
//   wr_data, wr_strobe      : flat write registers and their write pulses
//   bus_err                 : saturating count of illegal accesses
// -----------------------------------------------------------------------------
module fmc_mux_regbank
    import fmc_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                N_RD     = 16,
    parameter int                N_WR     = 8,
    parameter logic [ADDR_W-1:0] WR_BASE  = 8'h40,
    parameter logic [DATA_W-1:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     fmc_nadv,
    input  logic                     fmc_ne,
    input  logic                     fmc_nwe,
    input  logic                     fmc_noe,
    input  logic [DATA_W-1:0]        fmc_db_i,
    output logic [DATA_W-1:0]        fmc_db_o,
    output logic                     fmc_db_oe,
    input  logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_WR*DATA_W-1:0]   wr_data,
    output logic [N_WR-1:0]          wr_strobe,
    output logic [ERR_W-1:0]         bus_err
);

    localparam int SYNC_W = 4 + DATA_W;

    // Data goes through the same synchroniser as the strobes so both stay aligned.
    logic [SYNC_W-1:0] sync_in_s;
    logic [SYNC_W-1:0] sync_out_s;
    assign sync_in_s = {fmc_nadv, fmc_ne, fmc_nwe, fmc_noe, fmc_db_i};

    // Control bits reset to their idle (high) level so release creates no edges.
    fmc_sync #(
        .WIDTH   (SYNC_W),
        .RST_VAL ({4'b1111, {DATA_W{1'b0}}})
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (sync_in_s),
        .q     (sync_out_s)
    );

    logic              nadv_s, ne_s, nwe_s, noe_s;
    logic [DATA_W-1:0] db_s;
    assign nadv_s = sync_out_s[SYNC_W-1];
    assign ne_s   = sync_out_s[SYNC_W-2];
    assign nwe_s  = sync_out_s[SYNC_W-3];
    assign noe_s  = sync_out_s[SYNC_W-4];
    assign db_s   = sync_out_s[DATA_W-1:0];

    fmc_state_e          state_r;
    logic [3:0]          ctrl_prev_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                illegal_r;
    logic [DATA_W-1:0]   db_o_r;
    logic                db_oe_r;
    logic [N_WR*DATA_W-1:0] wr_data_r;
    logic [N_WR-1:0]     wr_strobe_r;
    logic [ERR_W-1:0]    bus_err_r;

    // Rising edges compare the synchronised level with a third stage.
    logic nadv_rise_s, ne_rise_s, nwe_rise_s, noe_rise_s;
    assign nadv_rise_s = nadv_s & ~ctrl_prev_r[3];
    assign ne_rise_s   = ne_s   & ~ctrl_prev_r[2];
    assign nwe_rise_s  = nwe_s  & ~ctrl_prev_r[1];
    assign noe_rise_s  = noe_s  & ~ctrl_prev_r[0];

    logic [N_RD*DATA_W-1:0] rd_src_s;

`ifdef FMC_SNAPSHOT_EN
    logic [N_RD*DATA_W-1:0] shadow_r;
    logic                   snap_s;
    // Freeze happens when the address phase of a channel-0 access closes.
    assign snap_s = (state_r == ST_ADDR) && nadv_rise_s && !ne_rise_s
                    && (db_s[ADDR_W-1:0] == {ADDR_W{1'b0}});

    // Shadow copy of every read channel, taken in a single cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_r <= '0;
        end else if (snap_s) begin
            shadow_r <= rd_data;
        end
    end
    assign rd_src_s = shadow_r;
`else
    assign rd_src_s = rd_data;
`endif

    // Address decode: AND-OR mux over read channels, write registers and ID.
    logic [DATA_W-1:0] rd_value_s;
    logic [N_RD-1:0]   rd_hit_s;
    logic [N_WR-1:0]   wr_sel_s;
    logic              id_hit_s;
    logic              rd_mapped_s;
    always_comb begin
        rd_value_s = '0;
        rd_hit_s   = '0;
        wr_sel_s   = '0;
        id_hit_s   = (addr_r == ADDR_W'(ADDR_ID));
        for (int k = 0; k < N_RD; k++) begin
            rd_hit_s[k] = (addr_r == ADDR_W'(k));
            rd_value_s  = rd_value_s | ({DATA_W{rd_hit_s[k]}} & rd_src_s[k*DATA_W +: DATA_W]);
        end
        for (int k = 0; k < N_WR; k++) begin
            wr_sel_s[k] = (addr_r == (WR_BASE + ADDR_W'(k)));
            rd_value_s  = rd_value_s | ({DATA_W{wr_sel_s[k]}} & wr_data_r[k*DATA_W +: DATA_W]);
        end
        rd_value_s  = rd_value_s | ({DATA_W{id_hit_s}} & ID_VALUE);
        rd_mapped_s = (|rd_hit_s) | (|wr_sel_s) | id_hit_s;
    end

    // Bus-cycle FSM with registered bus drive, write commit and error counting.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= ST_IDLE;
            ctrl_prev_r <= 4'b1111;
            addr_r      <= '0;
            illegal_r   <= 1'b0;
            db_o_r      <= '0;
            db_oe_r     <= 1'b0;
            wr_data_r   <= '0;
            wr_strobe_r <= '0;
            bus_err_r   <= '0;
        end else begin
            ctrl_prev_r <= {nadv_s, ne_s, nwe_s, noe_s};
            wr_strobe_r <= '0;
            if (ne_rise_s) begin
                state_r   <= ST_IDLE;
                db_oe_r   <= 1'b0;
                illegal_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!ne_s && !nadv_s) begin
                            state_r <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (nadv_rise_s) begin
                            state_r <= ST_WAIT;
                            addr_r  <= db_s[ADDR_W-1:0];
                        end
                    end
                    ST_WAIT: begin
                        if (!nadv_s) begin
                            state_r   <= ST_ADDR;
                            illegal_r <= 1'b0;
                        end else if (!noe_s && nwe_s) begin
                            state_r   <= ST_READ;
                            db_oe_r   <= 1'b1;
                            db_o_r    <= rd_value_s;
                            illegal_r <= 1'b0;
                            if (!rd_mapped_s) begin
                                bus_err_r <= err_sat_inc(bus_err_r);
                            end
                        end else if (!nwe_s && noe_s) begin
                            state_r   <= ST_WRITE;
                            illegal_r <= 1'b0;
                        end else if (!nwe_s && !noe_s) begin
                            // Count the collision once, however long it lasts.
                            illegal_r <= 1'b1;
                            if (!illegal_r) begin
                                bus_err_r <= err_sat_inc(bus_err_r);
                            end
                        end else begin
                            illegal_r <= 1'b0;
                        end
                    end
                    ST_READ: begin
                        if (noe_rise_s) begin
                            state_r <= ST_WAIT;
                            db_oe_r <= 1'b0;
                        end
                    end
                    ST_WRITE: begin
                        if (nwe_rise_s) begin
                            state_r <= ST_WAIT;
                            if (|wr_sel_s) begin
                                for (int k = 0; k < N_WR; k++) begin
                                    if (wr_sel_s[k]) begin
                                        wr_data_r[k*DATA_W +: DATA_W] <= db_s;
                                    end
                                end
                                wr_strobe_r <= wr_sel_s;
                            end else begin
                                bus_err_r <= err_sat_inc(bus_err_r);
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        db_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fmc_db_o  = db_o_r;
    assign fmc_db_oe = db_oe_r;
    assign wr_data   = wr_data_r;
    assign wr_strobe = wr_strobe_r;
    assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_fmc_mux_regbank.sv
// -----------------------------------------------------------------------------
// tb_fmc_mux_regbank
// Self-checking bench for fmc_mux_regbank: a table of bus transactions plus
// hand-written sequences for snapshot, collision, back-to-back, saturation and
// mid-read reset. Expected read data flows through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_fmc_mux_regbank;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n;
    logic           fmc_nadv, fmc_ne, fmc_nwe, fmc_noe;
    logic [15:0]    fmc_db_i;
    logic [15:0]    fmc_db_o;
    logic           fmc_db_oe;
    logic [255:0]   rd_data;
    logic [127:0]   wr_data;
    logic [7:0]     wr_strobe;
    logic [7:0]     bus_err;

    fmc_mux_regbank dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .fmc_nadv  (fmc_nadv),
        .fmc_ne    (fmc_ne),
        .fmc_nwe   (fmc_nwe),
        .fmc_noe   (fmc_noe),
        .fmc_db_i  (fmc_db_i),
        .fmc_db_o  (fmc_db_o),
        .fmc_db_oe (fmc_db_oe),
        .rd_data   (rd_data),
        .wr_data   (wr_data),
        .wr_strobe (wr_strobe),
        .bus_err   (bus_err)
    );

    always #5 sys_clk = ~sys_clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [15:0]   exp_q[$];
    logic [127:0]  wr_model;
    logic [7:0]    err_model;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;     // write value, or expected read value
        logic [7:0]  exp_err;  // bus_err after the transaction
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    function automatic bit is_mapped(input logic [7:0] a);
        return (a < 8'h10) || (a >= 8'h40 && a < 8'h48) || (a == 8'hFF);
    endfunction

    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic addr_phase(input logic [7:0] a);
        fmc_nadv = 1'b0;
        fmc_db_i = {8'h00, a};
        clk_wait(4);
        fmc_nadv = 1'b1;
        clk_wait(4);
    endtask

    task automatic read_phase(input logic [7:0] a, input logic [15:0] exp);
        @(negedge sys_clk);
        check("oe_before_read", 128'(fmc_db_oe), 128'(1'b0));
        fmc_noe = 1'b0;
        exp_q.push_back(exp);
        clk_wait(6);
        @(negedge sys_clk);
        check("oe_during_read", 128'(fmc_db_oe), 128'(1'b1));
        check("read_data", 128'(fmc_db_o), 128'(exp_q.pop_front()));
        fmc_noe = 1'b1;
        clk_wait(5);
        @(negedge sys_clk);
        check("oe_after_read", 128'(fmc_db_oe), 128'(1'b0));
        if (!is_mapped(a)) err_model = sat(err_model);
        check("bus_err_read", 128'(bus_err), 128'(err_model));
    endtask

    task automatic do_read(input logic [7:0] a, input logic [15:0] exp);
        fmc_ne = 1'b0;
        addr_phase(a);
        read_phase(a, exp);
        fmc_ne = 1'b1;
        clk_wait(4);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        int         pulses;
        logic [7:0] pat;
        logic [7:0] exp_pat;
        bit         in_rng;
        in_rng  = (a >= 8'h40) && (a < 8'h48);
        fmc_ne  = 1'b0;
        addr_phase(a);
        fmc_db_i = d;
        fmc_nwe  = 1'b0;
        clk_wait(4);
        fmc_nwe  = 1'b1;
        pulses = 0;
        pat    = 8'h00;
        repeat (8) begin
            @(negedge sys_clk);
            if (wr_strobe != 8'h00) begin
                pulses++;
                pat = pat | wr_strobe;
            end
        end
        if (in_rng) begin
            wr_model[(int'(a) - 64)*16 +: 16] = d;
            exp_pat = 8'(1 << (int'(a) - 64));
        end else begin
            exp_pat   = 8'h00;
            err_model = sat(err_model);
        end
        check("strobe_cycles", 128'(pulses), in_rng ? 128'd1 : 128'd0);
        check("strobe_pattern", 128'(pat), 128'(exp_pat));
        check("wr_data", wr_data, wr_model);
        check("bus_err_write", 128'(bus_err), 128'(err_model));
        fmc_ne = 1'b1;
        clk_wait(4);
    endtask

    initial begin
        int bad_oe;
        int bad_stb;

        vecs[0]  = '{1'b0, 8'hFF, 16'hF3C1, 8'd0};
        vecs[1]  = '{1'b1, 8'h42, 16'h1234, 8'd0};
        vecs[2]  = '{1'b0, 8'h42, 16'h1234, 8'd0};
        vecs[3]  = '{1'b0, 8'h00, 16'h0001, 8'd0};
        vecs[4]  = '{1'b0, 8'h03, 16'h0004, 8'd0};
        vecs[5]  = '{1'b0, 8'h0F, 16'h0010, 8'd0};
        vecs[6]  = '{1'b1, 8'h47, 16'hBEEF, 8'd0};
        vecs[7]  = '{1'b0, 8'h47, 16'hBEEF, 8'd0};
        vecs[8]  = '{1'b1, 8'h40, 16'hA5A5, 8'd0};
        vecs[9]  = '{1'b0, 8'h40, 16'hA5A5, 8'd0};
        vecs[10] = '{1'b0, 8'h30, 16'h0000, 8'd1};
        vecs[11] = '{1'b1, 8'h05, 16'h5555, 8'd2};
        vecs[12] = '{1'b1, 8'h48, 16'h1111, 8'd3};
        vecs[13] = '{1'b0, 8'h10, 16'h0000, 8'd4};
        vecs[14] = '{1'b1, 8'h3F, 16'h7777, 8'd5};

        for (int k = 0; k < 16; k++) rd_data[k*16 +: 16] = 16'(k + 1);
        wr_model  = '0;
        err_model = 8'h00;
        sys_rst_n = 1'b0;
        fmc_nadv  = 1'b1;
        fmc_ne    = 1'b1;
        fmc_nwe   = 1'b1;
        fmc_noe   = 1'b1;
        fmc_db_i  = 16'h0000;
        clk_wait(4);
        @(negedge sys_clk);
        check("rst_db_o", 128'(fmc_db_o), 128'd0);
        check("rst_db_oe", 128'(fmc_db_oe), 128'd0);
        check("rst_wr_data", wr_data, 128'd0);
        check("rst_strobe", 128'(wr_strobe), 128'd0);
        check("rst_bus_err", 128'(bus_err), 128'd0);
        sys_rst_n = 1'b1;
        clk_wait(4);

        // Table-driven transactions
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].data);
            check("table_bus_err", 128'(bus_err), 128'(vecs[i].exp_err));
        end

        // Snapshot coherence: channel 1 changes after channel 0 was read
        do_read(8'h00, 16'h0001);
        rd_data[1*16 +: 16] = 16'h00AA;
`ifdef FMC_SNAPSHOT_EN
        do_read(8'h01, 16'h0002);
`else
        do_read(8'h01, 16'h00AA);
`endif

        // noe and nwe low together in WAIT
        fmc_ne = 1'b0;
        addr_phase(8'h42);
        fmc_noe = 1'b0;
        fmc_nwe = 1'b0;
        bad_oe  = 0;
        bad_stb = 0;
        repeat (8) begin
            @(negedge sys_clk);
            if (fmc_db_oe !== 1'b0) bad_oe++;
            if (wr_strobe !== 8'h00) bad_stb++;
        end
        fmc_noe = 1'b1;
        fmc_nwe = 1'b1;
        repeat (6) begin
            @(negedge sys_clk);
            if (wr_strobe !== 8'h00) bad_stb++;
        end
        err_model = sat(err_model);
        check("collision_oe_cycles", 128'(bad_oe), 128'd0);
        check("collision_strobe_cycles", 128'(bad_stb), 128'd0);
        check("collision_bus_err", 128'(bus_err), 128'(err_model));
        check("collision_wr_data", wr_data, wr_model);
        fmc_ne = 1'b1;
        clk_wait(4);

        // Back-to-back accesses inside one chip-select
        fmc_ne = 1'b0;
        addr_phase(8'hFF);
        read_phase(8'hFF, 16'hF3C1);
        addr_phase(8'h47);
        read_phase(8'h47, 16'hBEEF);
        fmc_ne = 1'b1;
        clk_wait(4);

        // Error counter saturation
        repeat (300) do_write(8'h05, 16'hDEAD);
        check("bus_err_saturated", 128'(bus_err), 128'h0FF);

        // Reset in the middle of a read
        fmc_ne = 1'b0;
        addr_phase(8'hFF);
        fmc_noe = 1'b0;
        clk_wait(5);
        @(negedge sys_clk);
        check("midread_oe_before_reset", 128'(fmc_db_oe), 128'd1);
        sys_rst_n = 1'b0;
        #1;
        check("midread_oe_async_clear", 128'(fmc_db_oe), 128'd0);
        check("midread_bus_err_clear", 128'(bus_err), 128'd0);
        check("midread_wr_data_clear", wr_data, 128'd0);
        fmc_noe  = 1'b1;
        fmc_ne   = 1'b1;
        fmc_nadv = 1'b1;
        clk_wait(3);
        sys_rst_n = 1'b1;
        wr_model  = '0;
        err_model = 8'h00;
        clk_wait(3);
        do_read(8'hFF, 16'hF3C1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
